// File: rtl/dm_cache_ctrl.sv
// Direct-mapped cache controller: looks up valid/tag memories for a CPU read,
// fills the line from the next level on a miss, and keeps hit/miss statistics.
module dm_cache_ctrl #(
  parameter int INDEX_LEN  = 6,
  parameter int TAG_LEN    = 8,
  parameter int OFFSET_LEN = 2,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cpu_req,
  input  logic [TAG_LEN+INDEX_LEN+OFFSET_LEN-1:0] cpu_addr,
  output logic                          cpu_ready,
  output logic                          cpu_rvalid,
  output logic                          cpu_hit,
  output logic [INDEX_LEN-1:0]          vm_index,
  output logic                          vm_write,
  input  logic                          vm_valid,
  output logic                          tm_write,
  output logic [TAG_LEN-1:0]            tm_tag_out,
  input  logic [TAG_LEN-1:0]            tm_tag_in,
  output logic                          dm_write,
  output logic                          mem_req,
  output logic [TAG_LEN+INDEX_LEN-1:0]  mem_addr,
  input  logic                          mem_ack,
  output logic [CNT_W-1:0]              hit_count,
  output logic [CNT_W-1:0]              miss_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_COMPARE,
    S_FILL,
    S_UPDATE,
    S_RESPOND
  } state_t;

  state_t               state_reg, state_next;
  logic [TAG_LEN-1:0]   tag_reg, tag_next;
  logic [INDEX_LEN-1:0] index_reg, index_next;
  logic                 hit_reg, hit_next;
  logic [CNT_W-1:0]     hit_cnt_reg, hit_cnt_next;
  logic [CNT_W-1:0]     miss_cnt_reg, miss_cnt_next;

  logic [TAG_LEN-1:0]   req_tag;
  logic [INDEX_LEN-1:0] req_index;
  logic                 offset_unused;

  // The offset selects a word inside the line; the controller only tracks lines.
  assign req_tag       = cpu_addr[TAG_LEN+INDEX_LEN+OFFSET_LEN-1 -: TAG_LEN];
  assign req_index     = cpu_addr[OFFSET_LEN +: INDEX_LEN];
  assign offset_unused = ^cpu_addr[OFFSET_LEN-1:0];

  // Line address and fill tag always come from the latched request.
  assign mem_addr   = {tag_reg, index_reg};
  assign tm_tag_out = tag_reg;
  assign hit_count  = hit_cnt_reg;
  assign miss_count = miss_cnt_reg;

  // State, latched request and statistics registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      tag_reg      <= '0;
      index_reg    <= '0;
      hit_reg      <= 1'b0;
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      tag_reg      <= tag_next;
      index_reg    <= index_next;
      hit_reg      <= hit_next;
      hit_cnt_reg  <= hit_cnt_next;
      miss_cnt_reg <= miss_cnt_next;
    end
  end

  // Next-state and Moore outputs; every strobe defaults low.
  always_comb begin
    state_next    = state_reg;
    tag_next      = tag_reg;
    index_next    = index_reg;
    hit_next      = hit_reg;
    hit_cnt_next  = hit_cnt_reg;
    miss_cnt_next = miss_cnt_reg;
    cpu_ready     = 1'b0;
    cpu_rvalid    = 1'b0;
    cpu_hit       = 1'b0;
    vm_index      = index_reg;
    vm_write      = 1'b0;
    tm_write      = 1'b0;
    dm_write      = 1'b0;
    mem_req       = 1'b0;

    case (state_reg)
      S_IDLE: begin
        cpu_ready = 1'b1;
        if (cpu_req) begin
          // Present the index now so the registered reads start at the accept edge.
          vm_index   = req_index;
          tag_next   = req_tag;
          index_next = req_index;
          state_next = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        state_next = S_COMPARE;
      end
      S_COMPARE: begin
        if (vm_valid && (tm_tag_in == tag_reg)) begin
          hit_next = 1'b1;
          if (hit_cnt_reg != '1) hit_cnt_next = hit_cnt_reg + 1'b1;
          state_next = S_RESPOND;
        end else begin
          hit_next = 1'b0;
          if (miss_cnt_reg != '1) miss_cnt_next = miss_cnt_reg + 1'b1;
          state_next = S_FILL;
        end
      end
      S_FILL: begin
        mem_req = 1'b1;
        if (mem_ack) state_next = S_UPDATE;
      end
      S_UPDATE: begin
        vm_write   = 1'b1;
        tm_write   = 1'b1;
        dm_write   = 1'b1;
        state_next = S_RESPOND;
      end
      S_RESPOND: begin
        cpu_rvalid = 1'b1;
        cpu_hit    = hit_reg;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Self-checking bench for dm_cache_ctrl: directed scenarios plus randomized
// traffic checked against a line-level cache model kept in the bench.
module tb_dm_cache_ctrl;
  localparam int IL = 6;
  localparam int TL = 8;
  localparam int OL = 2;
  localparam int AL = TL + IL + OL;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset = 1'b1;
  logic           cpu_req = 1'b0;
  logic [AL-1:0]  cpu_addr = '0;
  logic           cpu_ready, cpu_rvalid, cpu_hit;
  logic [IL-1:0]  vm_index;
  logic           vm_write, tm_write, dm_write, mem_req;
  logic           vm_valid = 1'b0;
  logic [TL-1:0]  tm_tag_out;
  logic [TL-1:0]  tm_tag_in = '0;
  logic [TL+IL-1:0] mem_addr;
  logic           mem_ack = 1'b0;
  logic [15:0]    hit_count, miss_count;

  // Second instance with narrow counters to exercise saturation quickly.
  logic           s_req = 1'b0;
  logic [AL-1:0]  s_addr;
  logic           s_ready, s_rvalid, s_hit, s_vm_write, s_tm_write, s_dm_write, s_mem_req;
  logic [IL-1:0]  s_vm_index;
  logic [TL-1:0]  s_tm_tag_out, s_tm_tag_in;
  logic [TL+IL-1:0] s_mem_addr;
  logic           s_vm_valid, s_mem_ack;
  logic [2:0]     s_hit_count, s_miss_count;
  assign s_addr      = '0;
  assign s_vm_valid  = 1'b1;
  assign s_tm_tag_in = '0;
  assign s_mem_ack   = 1'b0;

  int checks = 0;
  int failures = 0;

  dm_cache_ctrl #(.INDEX_LEN(IL), .TAG_LEN(TL), .OFFSET_LEN(OL)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_hit(cpu_hit),
    .vm_index(vm_index), .vm_write(vm_write), .vm_valid(vm_valid),
    .tm_write(tm_write), .tm_tag_out(tm_tag_out), .tm_tag_in(tm_tag_in),
    .dm_write(dm_write), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  dm_cache_ctrl #(.INDEX_LEN(IL), .TAG_LEN(TL), .OFFSET_LEN(OL), .CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .cpu_req(s_req), .cpu_addr(s_addr),
    .cpu_ready(s_ready), .cpu_rvalid(s_rvalid), .cpu_hit(s_hit),
    .vm_index(s_vm_index), .vm_write(s_vm_write), .vm_valid(s_vm_valid),
    .tm_write(s_tm_write), .tm_tag_out(s_tm_tag_out), .tm_tag_in(s_tm_tag_in),
    .dm_write(s_dm_write), .mem_req(s_mem_req), .mem_addr(s_mem_addr), .mem_ack(s_mem_ack),
    .hit_count(s_hit_count), .miss_count(s_miss_count)
  );

  // Environment valid/tag memories with registered reads (hold while vm_write=1).
  logic          env_valid [64];
  logic [TL-1:0] env_tag [64];
  logic          env_clear = 1'b1;
  logic          pre_we = 1'b0;
  logic [IL-1:0] pre_idx = '0;
  logic [TL-1:0] pre_tag = '0;
  always @(posedge clk) begin
    if (env_clear) begin
      for (int i = 0; i < 64; i++) begin
        env_valid[i] <= 1'b0;
        env_tag[i]   <= '0;
      end
    end else begin
      if (pre_we) begin
        env_valid[pre_idx] <= 1'b1;
        env_tag[pre_idx]   <= pre_tag;
      end
      if (vm_write) env_valid[vm_index] <= 1'b1;
      if (tm_write) env_tag[vm_index] <= tm_tag_out;
    end
    if (!vm_write) begin
      vm_valid  <= env_valid[vm_index];
      tm_tag_in <= env_tag[vm_index];
    end
  end

  // Reference model: which lines are resident, and expected statistics.
  logic          exp_valid [64];
  logic [TL-1:0] exp_tag [64];
  int exp_hits = 0;
  int exp_misses = 0;
  int txn_no = 0;

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic preload(input logic [IL-1:0] idx, input logic [TL-1:0] tag);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = idx; pre_tag = tag;
    @(negedge clk);
    pre_we = 1'b0;
    exp_valid[idx] = 1'b1;
    exp_tag[idx]   = tag;
  endtask

  // One CPU read; ack_delay = extra FILL cycles before mem_ack.
  task automatic do_txn(input logic [AL-1:0] addr, input int ack_delay,
                        input bit hold_req, input bit stray_ack);
    logic [TL-1:0]    tag;
    logic [IL-1:0]    idx;
    logic [TL+IL-1:0] exp_maddr;
    bit  exp_hit, done, got_hit;
    int  guard, cyc, fill_cyc, upd_cyc, bad_upd, bad_addr, busy_ready, exp_lat;
    tag = addr[AL-1 -: TL];
    idx = addr[OL +: IL];
    exp_maddr = {tag, idx};
    exp_hit = exp_valid[idx] && (exp_tag[idx] == tag);
    guard = 0;
    @(negedge clk);
    while (!cpu_ready && guard < 50) begin @(negedge clk); guard++; end
    checks++;
    if (!cpu_ready) begin failures++; $display("FAIL ready_wait got=%0b exp=1", cpu_ready); end
    cpu_req = 1'b1; cpu_addr = addr;
    @(posedge clk);
    @(negedge clk);
    if (!hold_req) cpu_req = 1'b0;
    cpu_addr = AL'($urandom);
    cyc = 1; done = 0; got_hit = 0;
    fill_cyc = 0; upd_cyc = 0; bad_upd = 0; bad_addr = 0; busy_ready = 0;
    while (!done && cyc < 100) begin
      mem_ack = (cyc == 1) && stray_ack;
      if (cpu_ready) busy_ready++;
      if (mem_req) begin
        fill_cyc++;
        if (mem_addr !== exp_maddr) bad_addr++;
        if (fill_cyc == ack_delay + 1) mem_ack = 1'b1;
      end
      if (vm_write || tm_write || dm_write) begin
        upd_cyc++;
        if (!(vm_write && tm_write && dm_write) || tm_tag_out !== tag) bad_upd++;
      end
      if (cpu_rvalid) begin
        got_hit = cpu_hit; done = 1;
      end else begin
        @(negedge clk); cyc++;
      end
    end
    mem_ack = 1'b0;
    exp_lat = exp_hit ? 3 : 5 + ack_delay;
    if (exp_hit) exp_hits++; else exp_misses++;
    if (!exp_hit) begin exp_valid[idx] = 1'b1; exp_tag[idx] = tag; end
    txn_no++;
    $display("txn %0d addr=%h exp_hit=%0b hit=%0b lat=%0d ack_delay=%0d", txn_no, addr, exp_hit, got_hit, cyc, ack_delay);
    checks++; if (!done) begin failures++; $display("FAIL rvalid_timeout got=0 exp=1"); end
    checks++; if (got_hit !== exp_hit) begin failures++; $display("FAIL cpu_hit got=%0b exp=%0b", got_hit, exp_hit); end
    checks++; if (cyc != exp_lat) begin failures++; $display("FAIL latency got=%0d exp=%0d", cyc, exp_lat); end
    checks++; if (fill_cyc != (exp_hit ? 0 : ack_delay + 1)) begin failures++; $display("FAIL fill_cycles got=%0d exp=%0d", fill_cyc, exp_hit ? 0 : ack_delay + 1); end
    checks++; if (upd_cyc != (exp_hit ? 0 : 1) || bad_upd != 0) begin failures++; $display("FAIL update_pulse got=%0d/%0d exp=%0d/0", upd_cyc, bad_upd, exp_hit ? 0 : 1); end
    checks++; if (bad_addr != 0) begin failures++; $display("FAIL mem_addr got=%h exp=%h", mem_addr, exp_maddr); end
    checks++; if (busy_ready != 0) begin failures++; $display("FAIL busy_ready got=%0d exp=0", busy_ready); end
    checks++; if (hit_count !== 16'(sat16(exp_hits))) begin failures++; $display("FAIL hit_count got=%0d exp=%0d", hit_count, sat16(exp_hits)); end
    checks++; if (miss_count !== 16'(sat16(exp_misses))) begin failures++; $display("FAIL miss_count got=%0d exp=%0d", miss_count, sat16(exp_misses)); end
    @(negedge clk);
    cpu_req = 1'b0;
    checks++; if (cpu_rvalid !== 1'b0 || cpu_ready !== 1'b1) begin failures++; $display("FAIL after_respond got=rv%0b/rdy%0b exp=rv0/rdy1", cpu_rvalid, cpu_ready); end
  endtask

  task automatic test_reset();
    reset = 1'b1; env_clear = 1'b1;
    cpu_req = 1'b1; cpu_addr = 16'h1234;
    for (int i = 0; i < 64; i++) begin exp_valid[i] = 1'b0; exp_tag[i] = '0; end
    exp_hits = 0; exp_misses = 0;
    repeat (3) @(negedge clk);
    checks++; if (cpu_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ignored got=%0b exp=1", cpu_ready); end
    cpu_req = 1'b0;
    @(negedge clk);
    reset = 1'b0; env_clear = 1'b0;
    @(negedge clk);
    checks++; if (cpu_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", cpu_ready); end
    checks++; if (cpu_rvalid !== 1'b0 || cpu_hit !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%0b%0b exp=00", cpu_rvalid, cpu_hit); end
    checks++; if ({vm_write, tm_write, dm_write, mem_req} !== 4'b0) begin failures++; $display("FAIL reset_strobes got=%b exp=0000", {vm_write, tm_write, dm_write, mem_req}); end
    checks++; if (vm_index !== '0 || mem_addr !== '0 || tm_tag_out !== '0) begin failures++; $display("FAIL reset_addr got=%h/%h/%h exp=0/0/0", vm_index, mem_addr, tm_tag_out); end
    checks++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", hit_count, miss_count); end
  endtask

  task automatic test_cold_miss();
    do_txn(16'h1234, 2, 1'b0, 1'b0);
  endtask

  task automatic test_hit();
    do_txn(16'h1234, 0, 1'b0, 1'b0);
  endtask

  task automatic test_conflict();
    preload(6'h0D, 8'h34);
    do_txn(16'h1234, 1, 1'b0, 1'b0);
    do_txn(16'h1236, 0, 1'b0, 1'b0);
  endtask

  task automatic test_busy();
    do_txn(16'hAB81, 3, 1'b1, 1'b1);
    do_txn(16'hAB82, 0, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    logic [AL-1:0] a;
    for (int n = 0; n < 150; n++) begin
      a = {8'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      do_txn(a, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        checks++; if (mem_req !== 1'b0 || cpu_ready !== 1'b1) begin failures++; $display("FAIL idle_stray_ack got=req%0b/rdy%0b exp=req0/rdy1", mem_req, cpu_ready); end
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    int guard, rv_seen;
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 16'h5678;
    @(negedge clk);
    cpu_req = 1'b0;
    guard = 0;
    while (!mem_req && guard < 10) begin @(negedge clk); guard++; end
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL midfill_reach got=%0b exp=1", mem_req); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_hits = 0; exp_misses = 0;
    checks++; if (mem_req !== 1'b0 || cpu_ready !== 1'b1 || cpu_rvalid !== 1'b0) begin failures++; $display("FAIL midfill_state got=req%0b/rdy%0b/rv%0b exp=req0/rdy1/rv0", mem_req, cpu_ready, cpu_rvalid); end
    checks++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin failures++; $display("FAIL midfill_counts got=%0d/%0d exp=0/0", hit_count, miss_count); end
    rv_seen = 0;
    repeat (6) begin
      mem_ack = 1'b1;
      @(negedge clk);
      if (cpu_rvalid || mem_req || !cpu_ready) rv_seen++;
    end
    mem_ack = 1'b0;
    checks++; if (rv_seen != 0) begin failures++; $display("FAIL midfill_quiet got=%0d exp=0", rv_seen); end
    do_txn(16'h5678, 0, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    int n, cyc, exp_cnt;
    @(negedge clk);
    checks++; if (s_hit_count !== 3'd0) begin failures++; $display("FAIL sat_start got=%0d exp=0", s_hit_count); end
    s_req = 1'b1;
    n = 0; cyc = 0;
    while (n < 12 && cyc < 200) begin
      @(negedge clk); cyc++;
      if (s_rvalid) begin
        n++;
        exp_cnt = (n > 7) ? 7 : n;
        $display("sat txn %0d hit=%0b hit_count=%0d exp=%0d", n, s_hit, s_hit_count, exp_cnt);
        checks++; if (s_hit !== 1'b1 || s_hit_count !== 3'(exp_cnt)) begin failures++; $display("FAIL sat_count got=%0b/%0d exp=1/%0d", s_hit, s_hit_count, exp_cnt); end
      end
    end
    s_req = 1'b0;
    checks++; if (n != 12) begin failures++; $display("FAIL sat_timeout got=%0d exp=12", n); end
    checks++; if (s_miss_count !== 3'd0 || s_mem_req !== 1'b0) begin failures++; $display("FAIL sat_miss got=%0d exp=0", s_miss_count); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_busy();
    test_random();
    test_reset_mid_fill();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
